data_memory_controller: RTL and testbench

- Backing-store side of the data cache: services one word-sized read or write per request over the cache's start/stop handshake.
- Owns a word-organised RAM and models fixed multi-cycle memory latency.
- Sits directly downstream of the data cache.
  - Cache drives mem_addr / mem_we / mem_data_in / interupt_start.
  - This block returns mem_data_out / interupt_stop.

---
 rtl/data_memory_controller_if.sv | 34 +++
 rtl/data_memory_controller.sv | 128 ++++++++++++
 tb/tb_data_memory_controller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_controller_if.sv
// Cache <-> backing-memory request/done bus for data_memory_controller.
// The cache side is the master, the memory controller is the slave.
interface data_memory_controller_if;
  logic            interupt_start;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [3:0][7:0] mem_data_in;
  logic [3:0][7:0] mem_data_out;
  logic            interupt_stop;
  logic            mem_err;
  logic            busy;

  modport master (
    output interupt_start,
    output mem_we,
    output mem_addr,
    output mem_data_in,
    input  mem_data_out,
    input  interupt_stop,
    input  mem_err,
    input  busy
  );

  modport slave (
    input  interupt_start,
    input  mem_we,
    input  mem_addr,
    input  mem_data_in,
    output mem_data_out,
    output interupt_stop,
    output mem_err,
    output busy
  );
endinterface

// File: rtl/data_memory_controller.sv
// Word-organised backing RAM behind the data cache: one read or write per
// start/stop handshake, with a fixed multi-cycle latency and range checking.
module data_memory_controller #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  data_memory_controller_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [AW-1:0]   r_idx;
  logic            r_oor;
  logic [3:0][7:0] r_wdata;
  logic [3:0][7:0] r_rdata;
  logic            r_stop;
  logic            r_err;
  logic            r_busy;

  logic [3:0][7:0] r_ram [DEPTH];

  logic [AW-1:0]   w_idx;
  logic            w_oor;
  logic            w_commit;
  logic            w_wr_en;
  logic            w_unused_ok;

  // Byte offset bits never select anything; any bit above the word index is out of range.
  assign w_idx       = bus.mem_addr[AW+1:2];
  assign w_oor       = (bus.mem_addr >> (AW + 2)) != 32'd0;
  assign w_unused_ok = &{1'b0, bus.mem_addr[1:0]};

  assign w_commit = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_wr_en  = w_commit && r_we && !r_oor;

  // RAM has no reset; a reset before the commit edge forces IDLE so the write never fires.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_ram[r_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_oor   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_stop  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.interupt_start) begin
            r_we    <= bus.mem_we;
            r_idx   <= w_idx;
            r_oor   <= w_oor;
            r_wdata <= bus.mem_data_in;
            r_cnt   <= 4'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
        end

        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            if (!r_we) begin
              r_rdata <= r_oor ? '0 : r_ram[r_idx];
            end
            r_stop  <= 1'b1;
            r_err   <= r_oor;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_DONE: begin
          r_stop <= 1'b0;
          r_err  <= 1'b0;
          // A cache still holding start must drop it before another request is taken.
          if (bus.interupt_start) begin
            r_state <= S_RELEASE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_RELEASE: begin
          if (!bus.interupt_start) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_stop  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_data_out  = r_rdata;
  assign bus.interupt_stop = r_stop;
  assign bus.mem_err       = r_err;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller: a vector table of single requests
// plus hand-written sequences for reset, held start and inputs changing mid-access.
module tb_data_memory_controller;

  localparam int DEPTH   = 4096;
  localparam int LATENCY = 4;

  logic clk;
  logic reset;

  data_memory_controller_if bus ();

  data_memory_controller #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.mem_we         = we;
    bus.mem_addr       = addr;
    bus.mem_data_in    = data;
    bus.interupt_start = 1'b1;
  endtask

  // Counts negedges after the request until stop is seen; the first negedge follows the accept edge.
  task automatic wait_stop(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.interupt_stop && cyc < 40);
    check("stop_timeout", 32'(bus.interupt_stop), 32'd1);
  endtask

  task automatic end_req(input int hold);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("held_stop_low", 32'(bus.interupt_stop), 32'd0);
      check("held_busy", 32'(bus.busy), 32'd1);
    end
    bus.interupt_start = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_err", 32'(bus.mem_err), 32'd0);
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_data, input logic exp_err, input int hold);
    int cyc;
    start_req(we, addr, data);
    wait_stop(cyc);
    check("latency", 32'(cyc), 32'(LATENCY + 1));
    check("data_out", bus.mem_data_out, exp_data);
    check("err", 32'(bus.mem_err), 32'(exp_err));
    check("busy_at_stop", 32'(bus.busy), 32'd1);
    $display("[TB] %s addr=%h wdata=%h data_out=%h err=%0d cycles=%0d",
             we ? "WR" : "RD", addr, data, bus.mem_data_out, bus.mem_err, cyc);
    end_req(hold);
  endtask

  initial begin
    int cyc;
    int stops;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h4433_2211, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'h4433_2211, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h4433_2211, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0023, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'hA5A5_0001, 32'hDEAD_BEEF, 1'b0};
    vecs[5]  = '{1'b0, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_0001, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_3FFC, 32'h1234_5678, 32'hA5A5_0001, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_3FFE, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_4000, 32'h0000_0000, 32'h0000_0000, 1'b1};

    reset              = 1'b1;
    bus.interupt_start = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = 32'h0;
    bus.mem_data_in    = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_stop", 32'(bus.interupt_stop), 32'd0);
    check("rst_err", 32'(bus.mem_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_data", bus.mem_data_out, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_err, 0);
    end

    // Byte lanes of the last read individually.
    do_req(1'b0, 32'h0000_0010, 32'h0, 32'h4433_2211, 1'b0, 0);
    check("byte0", 32'(bus.mem_data_out[0]), 32'h11);
    check("byte3", 32'(bus.mem_data_out[3]), 32'h44);

    // Asynchronous reset mid-cycle clears outputs before any clock edge.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_data", bus.mem_data_out, 32'h0);
    check("async_rst_stop", 32'(bus.interupt_stop), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] async reset applied mid-cycle");

    // Start held 3 cycles past stop: one access, one pulse, idle one edge after release.
    do_req(1'b1, 32'h0000_0050, 32'hCAFE_F00D, 32'h0, 1'b0, 3);
    do_req(1'b0, 32'h0000_0050, 32'h0, 32'hCAFE_F00D, 1'b0, 0);

    // Inputs change while BUSY: the captured write to 0x40 must win.
    do_req(1'b1, 32'h0000_0080, 32'h8080_8080, 32'hCAFE_F00D, 1'b0, 0);
    start_req(1'b1, 32'h0000_0040, 32'h4040_4040);
    @(negedge clk);
    @(negedge clk);
    bus.mem_addr    = 32'h0000_0080;
    bus.mem_we      = 1'b0;
    bus.mem_data_in = 32'h1111_1111;
    wait_stop(cyc);
    check("chg_latency", 32'(cyc + 2), 32'(LATENCY + 1));
    check("chg_data_hold", bus.mem_data_out, 32'hCAFE_F00D);
    $display("[TB] WR addr=00000040 with mid-latency input change, cycles=%0d", cyc + 2);
    end_req(0);
    do_req(1'b0, 32'h0000_0040, 32'h0, 32'h4040_4040, 1'b0, 0);
    do_req(1'b0, 32'h0000_0080, 32'h0, 32'h8080_8080, 1'b0, 0);

    // Reset during the latency of a write to 0x30 aborts it.
    do_req(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 32'h8080_8080, 1'b0, 0);
    start_req(1'b1, 32'h0000_0030, 32'h5555_AAAA);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    bus.interupt_start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    stops = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.interupt_stop) stops++;
    end
    check("abort_no_stop", 32'(stops), 32'd0);
    $display("[TB] reset during write to 00000030, stop pulses after=%0d", stops);
    do_req(1'b0, 32'h0000_0030, 32'h0, 32'h0BAD_F00D, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
